// File: rtl/rr_token_arbiter_if.sv
// rr_token_arbiter_if: request/grant bundle between clients and the round-robin arbiter
interface rr_token_arbiter_if #(
    parameter int NREQ = 3
);
    localparam int OW = $clog2(NREQ + 1);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [OW-1:0]   owner;
    logic            busy;
    logic            revoke;
    logic            starve;
    modport master (output req, input ack, owner, busy, revoke, starve);
    modport slave  (input req, output ack, owner, busy, revoke, starve);
endinterface

// File: rtl/rr_token_arbiter.sv
// rr_token_arbiter: round-robin req/ack arbiter with hold watchdog and sticky starvation flag
module rr_token_arbiter #(
    parameter int NREQ       = 3,
    parameter int HOLD_MAX   = 8,
    parameter int STARVE_MAX = 12,
    parameter int CNT_W      = 4
) (
    input logic               clk,
    input logic               rst,
    rr_token_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
    logic            revoke_q, revoke_d, starve_q, starve_d, found;
    logic [2*NREQ-1:0] rot;
    logic [CNT_W-1:0] wait_q [NREQ];
    logic [CNT_W-1:0] wait_d [NREQ];
    assign bus.ack    = ack_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = (state_q == BUSY);
    assign bus.revoke = revoke_q;
    assign bus.starve = starve_q;
    // Rotate requests so the pointer sits at bit 0; lowest rotated bit is the winner
    always_comb begin
        rot   = {bus.req, bus.req} >> ptr_q;
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                win   = (int'(ptr_q) + k >= NREQ) ? OW'(int'(ptr_q) + k - NREQ) : OW'(int'(ptr_q) + k);
            end
        end
    end
    // Next-state and grant logic; ack is only withdrawn once the owner drops req
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        ack_d    = ack_q;
        hold_d   = hold_q;
        revoke_d = revoke_q;
        hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = BUSY;
                    ack_d    = NREQ'(1) << win;
                    owner_d  = win;
                    hold_d   = '0;
                    revoke_d = 1'b0;
                end
            end
            BUSY: begin
                if (~|(bus.req & ack_q)) begin
                    state_d  = RELEASE;
                    ack_d    = '0;
                    owner_d  = OW'(NREQ);
                    revoke_d = 1'b0;
                    ptr_d    = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end else begin
                    hold_d = hold_inc;
                    if (hold_inc == CNT_W'(HOLD_MAX)) revoke_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Per-client wait counters run while a request is pending without a grant
    always_comb begin
        starve_d = starve_q;
        for (int j = 0; j < NREQ; j++) begin
            wait_d[j] = (!bus.req[j] || ack_q[j]) ? '0 : ((wait_q[j] == '1) ? wait_q[j] : wait_q[j] + 1'b1);
            if (wait_d[j] == CNT_W'(STARVE_MAX)) starve_d = 1'b1;
        end
    end
    // State register; reset drops any grant immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= OW'(NREQ);
            ack_q    <= '0;
            hold_q   <= '0;
            revoke_q <= 1'b0;
            starve_q <= 1'b0;
            for (int j = 0; j < NREQ; j++) wait_q[j] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            ack_q    <= ack_d;
            hold_q   <= hold_d;
            revoke_q <= revoke_d;
            starve_q <= starve_d;
            for (int j = 0; j < NREQ; j++) wait_q[j] <= wait_d[j];
        end
    end
endmodule

// File: tb/tb_rr_token_arbiter.sv
// tb_rr_token_arbiter: scoreboard bench with a behavioural arbiter model and randomized clients
module tb_rr_token_arbiter;
    localparam int N   = 3;
    localparam int HM  = 8;
    localparam int SM  = 12;
    localparam int CW  = 4;
    localparam int OW  = $clog2(N + 1);
    localparam int SAT = (1 << CW) - 1;
    typedef struct packed {
        logic [N-1:0]  ack;
        logic [OW-1:0] owner;
        logic          busy;
        logic          revoke;
        logic          starve;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    int   m_own, m_ptr, m_ph, m_hold;
    int   m_w[N];
    bit   m_rev, m_stv;
    rr_token_arbiter_if #(.NREQ(N)) bus ();
    rr_token_arbiter #(.NREQ(N), .HOLD_MAX(HM), .STARVE_MAX(SM), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic model_reset();
        m_own = -1;
        m_ptr = 0;
        m_ph = 0;
        m_hold = 0;
        m_rev = 0;
        m_stv = 0;
        for (int j = 0; j < N; j++) m_w[j] = 0;
    endtask
    // One clock edge of the arbiter as described in words: waits, then grant/hold/release
    task automatic model_step(input int rv);
        bit got;
        for (int j = 0; j < N; j++) begin
            if (((rv >> j) & 1) == 0 || m_own == j) m_w[j] = 0;
            else begin
                if (m_w[j] < SAT) m_w[j]++;
                if (m_w[j] == SM) m_stv = 1;
            end
        end
        if (m_ph == 0) begin
            got = 0;
            for (int k = 0; k < N; k++) begin
                if (!got && ((rv >> ((m_ptr + k) % N)) & 1) == 1) begin
                    got = 1;
                    m_own = (m_ptr + k) % N;
                end
            end
            if (got) begin
                m_hold = 0;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (((rv >> m_own) & 1) == 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_rev = 0;
                m_ph = 2;
            end else begin
                if (m_hold < SAT) m_hold++;
                if (m_hold == HM) m_rev = 1;
            end
        end else m_ph = 0;
    endtask
    task automatic cyc(input int rv, input bit do_rst);
        exp_t e;
        @(negedge clk);
        bus.req = N'(rv);
        rst = do_rst;
        if (do_rst) model_reset();
        else model_step(rv);
        e.ack    = (m_own < 0) ? '0 : N'(1 << m_own);
        e.owner  = (m_own < 0) ? OW'(N) : OW'(m_own);
        e.busy   = (m_ph == 1);
        e.revoke = m_rev;
        e.starve = m_stv;
        q.push_back(e);
    endtask
    task automatic run(input int rv, input int n);
        repeat (n) cyc(rv, 0);
    endtask
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, want, $time);
        end
    endtask
    // Monitor: one expected output set per clock edge, sampled just after the edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ack", 32'(bus.ack), 32'(e.ack));
            chk("owner", 32'(bus.owner), 32'(e.owner));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("revoke", 32'(bus.revoke), 32'(e.revoke));
            chk("starve", 32'(bus.starve), 32'(e.starve));
            chk("ack_onehot", 32'($countones(bus.ack) <= 1), 32'd1);
            chk("owner_iff_ack", 32'((bus.owner == OW'(N)) == (bus.ack == '0)), 32'd1);
        end
    end
    initial begin
        int rv;
        bus.req = '0;
        model_reset();
        cyc(0, 1);
        run(0, 10);
        cyc(7, 1);
        repeat (30) begin
            rv = 7;
            if (m_own >= 0 && m_hold >= 1) rv &= ~(1 << m_own);
            cyc(rv, 0);
        end
        cyc(0, 1);
        run(2, 20);
        run(0, 3);
        cyc(0, 1);
        cyc(1, 0);
        run(5, 15);
        run(4, 4);
        run(0, 2);
        run(2, 3);
        run(0, 3);
        cyc(0, 1);
        run(4, 3);
        cyc(4, 1);
        run(5, 3);
        run(0, 3);
        cyc(0, 1);
        run(4, 2);
        cyc(0, 0);
        cyc(3, 0);
        cyc(2, 0);
        run(2, 2);
        run(0, 2);
        cyc(0, 1);
        for (int i = 0; i < 600; i++) begin
            rv = 0;
            for (int j = 0; j < N; j++) begin
                if (m_own == j) begin
                    if ($urandom_range(0, 11) != 0) rv |= 1 << j;
                end else if ($urandom_range(0, 2) != 0) rv |= 1 << j;
            end
            cyc(rv, $urandom_range(0, 249) == 0);
        end
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
